// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_queue_pkg;

  localparam int unsigned INST_BYTES = 4;
  localparam int unsigned ENTRY_XLEN = 32;

  typedef struct packed {
    logic [ENTRY_XLEN-1:0] pc;
    logic [ENTRY_XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Synchronous FIFO with flush; power-of-two depth, pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [WIDTH-1:0]             head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             do_push, do_pop;

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      cnt    <= cnt_n;
    end
  end

  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    cnt_n    = cnt;
    if (flush) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      cnt_n    = '0;
    end else begin
      if (do_push) wr_ptr_n = wr_ptr + PW'(1);
      if (do_pop)  rd_ptr_n = rd_ptr + PW'(1);
      cnt_n = cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: only entries counted by cnt are ever observed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, credit-limited requests,
// in-order response buffering, and redirect with stale-response dropping.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic            error
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0]   fetch_pc, fetch_pc_n, resp_pc, resp_pc_n, redirect_aligned;
  logic [CW-1:0]     in_flight, in_flight_n, drop_cnt, drop_cnt_n;
  logic [CW-1:0]     fifo_count, live, in_flight_after;
  logic [CW:0]       credit_used;
  logic              error_q, error_n;
  logic              fifo_full, fifo_empty;
  logic              req_ok, req_fire, resp_known, resp_drop, push, pop;
  logic [2*XLEN-1:0] head;

  assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

  // Live requests are those whose responses will actually be enqueued.
  assign live        = in_flight - drop_cnt;
  assign credit_used = (CW+1)'(fifo_count) + (CW+1)'(live);
  assign req_ok      = !rst && !redirect_valid && !fifo_full &&
                       (credit_used < (CW+1)'(DEPTH));
  assign req_fire    = req_ok && imem_req_ready;

  assign resp_known      = imem_resp_valid && (in_flight != '0);
  assign resp_drop       = resp_known && (drop_cnt != '0);
  assign push            = resp_known && (drop_cnt == '0) && !redirect_valid;
  assign in_flight_after = in_flight - CW'(resp_known);

  assign out_valid = !rst && !fifo_empty;
  assign pop       = out_valid && out_ready;

  sync_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({resp_pc, imem_resp_data}),
    .pop       (pop),
    .flush     (redirect_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      resp_pc   <= RESET_PC;
      in_flight <= '0;
      drop_cnt  <= '0;
      error_q   <= 1'b0;
    end else begin
      fetch_pc  <= fetch_pc_n;
      resp_pc   <= resp_pc_n;
      in_flight <= in_flight_n;
      drop_cnt  <= drop_cnt_n;
      error_q   <= error_n;
    end
  end

  always_comb begin
    fetch_pc_n  = fetch_pc;
    resp_pc_n   = resp_pc;
    in_flight_n = in_flight_after + CW'(req_fire);
    drop_cnt_n  = drop_cnt - CW'(resp_drop);
    error_n     = error_q;
    if (redirect_valid) begin
      // Everything still outstanding after this cycle predates the redirect.
      fetch_pc_n = redirect_aligned;
      resp_pc_n  = redirect_aligned;
      drop_cnt_n = in_flight_after;
      if (redirect_pc[1:0] != 2'b00) error_n = 1'b1;
    end else begin
      if (req_fire) fetch_pc_n = fetch_pc + XLEN'(INST_BYTES);
      if (push)     resp_pc_n  = resp_pc + XLEN'(INST_BYTES);
    end
    if (imem_resp_valid && (in_flight == '0)) error_n = 1'b1;
  end

  assign imem_req_valid = req_ok;
  assign imem_req_addr  = rst ? '0 : fetch_pc;
  assign out_pc         = rst ? '0 : head[2*XLEN-1:XLEN];
  assign out_inst       = rst ? '0 : head[XLEN-1:0];
  assign error          = error_q && !rst;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and randomised bench for fetch_queue with an in-order variable-latency memory model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        error;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .error           (error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int mem_lat = 1;
  int last_due = 0;
  int n_fire = 0;
  logic spur = 1'b0;
  logic [31:0] q_addr [$];
  int          q_due  [$];

  logic        obs_req_valid, obs_out_valid, obs_pop, obs_err, obs_resp;
  logic [31:0] obs_addr, obs_pc, obs_inst;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return (pc * 32'd3) ^ 32'h1357_9BDF;
  endfunction

  // One cycle: drive memory response, sample outputs, record request fire, advance.
  task automatic tick();
    int d;
    if (spur) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hBAD0_0000;
    end else if (q_due.size() != 0 && q_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = inst_of(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    #1;
    obs_req_valid = imem_req_valid;
    obs_addr      = imem_req_addr;
    obs_out_valid = out_valid;
    obs_pc        = out_pc;
    obs_inst      = out_inst;
    obs_err       = error;
    obs_resp      = imem_resp_valid;
    obs_pop       = out_valid && out_ready;
    if (imem_req_valid && imem_req_ready) begin
      d = cyc + mem_lat;
      if (d <= last_due) d = last_due + 1;
      q_addr.push_back(imem_req_addr);
      q_due.push_back(d);
      last_due = d;
      n_fire++;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    imem_req_ready = 1'b1;
    spur = 1'b0;
    mem_lat = 1;
    q_addr.delete();
    q_due.delete();
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
    last_due = 0;
    n_fire = 0;
    q_addr.delete();
    q_due.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (obs_out_valid !== 1'b0 || obs_req_valid !== 1'b0 || obs_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: out_valid=%b req_valid=%b error=%b, required all 0",
               obs_out_valid, obs_req_valid, obs_err);
    end
    rst = 1'b0;
    cyc = 0;
    last_due = 0;
    q_addr.delete();
    q_due.delete();
    tick();
    checks++;
    if (obs_out_valid !== 1'b0 || obs_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_after: out_valid=%b error=%b, required 0 0", obs_out_valid, obs_err);
    end
    checks++;
    if (obs_req_valid !== 1'b1 || obs_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_first_req: valid=%b addr=%h, required 1 00000000",
               obs_req_valid, obs_addr);
    end
  endtask

  task automatic test_stream();
    int pops;
    logic [31:0] exp_pc;
    do_reset();
    out_ready = 1'b1;
    pops = 0;
    exp_pc = 32'h0;
    repeat (16) begin
      tick();
      if (obs_pop) begin
        checks++;
        if (obs_pc !== exp_pc || obs_inst !== inst_of(exp_pc)) begin
          errors++;
          $display("FAIL stream_order: pc=%h inst=%h, required pc=%h inst=%h",
                   obs_pc, obs_inst, exp_pc, inst_of(exp_pc));
        end
        exp_pc += 32'd4;
        pops++;
      end
    end
    checks++;
    if (pops !== 14) begin
      errors++;
      $display("FAIL stream_rate: pops=%0d, required 14", pops);
    end
    checks++;
    if (obs_err !== 1'b0) begin
      errors++;
      $display("FAIL stream_error: error=%b, required 0", obs_err);
    end
  endtask

  task automatic test_backpressure();
    int pops;
    logic [31:0] exp_pc;
    do_reset();
    out_ready = 1'b0;
    repeat (12) tick();
    checks++;
    if (n_fire !== 4) begin
      errors++;
      $display("FAIL bp_fires: fires=%0d, required 4", n_fire);
    end
    checks++;
    if (obs_req_valid !== 1'b0 || obs_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall: req_valid=%b out_valid=%b, required 0 1",
               obs_req_valid, obs_out_valid);
    end
    out_ready = 1'b1;
    pops = 0;
    exp_pc = 32'h0;
    repeat (12) begin
      tick();
      if (obs_pop) begin
        checks++;
        if (obs_pc !== exp_pc || obs_inst !== inst_of(exp_pc)) begin
          errors++;
          $display("FAIL bp_order: pc=%h inst=%h, required pc=%h inst=%h",
                   obs_pc, obs_inst, exp_pc, inst_of(exp_pc));
        end
        exp_pc += 32'd4;
        pops++;
      end
    end
    checks++;
    if (pops < 8 || n_fire <= 4) begin
      errors++;
      $display("FAIL bp_resume: pops=%0d fires=%0d, required pops>=8 fires>4", pops, n_fire);
    end
  endtask

  task automatic test_redirect_drop();
    int got;
    do_reset();
    out_ready = 1'b0;
    mem_lat = 3;
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    checks++;
    if (obs_req_valid !== 1'b0 || obs_resp !== 1'b1) begin
      errors++;
      $display("FAIL drop_redirect_cycle: req_valid=%b resp=%b, required 0 1",
               obs_req_valid, obs_resp);
    end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && got < 2; i++) begin
      tick();
      if (obs_pop) begin
        checks++;
        if (obs_pc !== 32'h100 + 32'(got * 4) || obs_inst !== inst_of(32'h100 + 32'(got * 4))) begin
          errors++;
          $display("FAIL drop_first_pc: pop%0d pc=%h inst=%h, required pc=%h", got,
                   obs_pc, obs_inst, 32'h100 + 32'(got * 4));
        end
        got++;
      end
    end
    checks++;
    if (got !== 2) begin
      errors++;
      $display("FAIL drop_timeout: pops=%0d, required 2", got);
    end
  endtask

  task automatic test_redirect_collide();
    int got;
    do_reset();
    out_ready = 1'b0;
    mem_lat = 1;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    out_ready = 1'b1;
    tick();
    checks++;
    if (obs_pop !== 1'b1 || obs_pc !== 32'h0 || obs_resp !== 1'b1 || obs_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL collide_cycle: pop=%b pc=%h resp=%b req=%b, required 1 00000000 1 0",
               obs_pop, obs_pc, obs_resp, obs_req_valid);
    end
    redirect_valid = 1'b0;
    tick();
    checks++;
    if (obs_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL collide_empty: out_valid=%b, required 0", obs_out_valid);
    end
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      tick();
      if (obs_pop) begin
        checks++;
        if (obs_pc !== 32'h200 || obs_inst !== inst_of(32'h200)) begin
          errors++;
          $display("FAIL collide_next: pc=%h inst=%h, required pc=00000200 inst=%h",
                   obs_pc, obs_inst, inst_of(32'h200));
        end
        got++;
      end
    end
    checks++;
    if (got !== 1) begin
      errors++;
      $display("FAIL collide_timeout: pops=%0d, required 1", got);
    end
  endtask

  task automatic test_error();
    int got;
    do_reset();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++;
    if (obs_err !== 1'b1) begin
      errors++;
      $display("FAIL err_misalign: error=%b, required 1", obs_err);
    end
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      tick();
      if (obs_pop) begin
        checks++;
        if (obs_pc !== 32'h100) begin
          errors++;
          $display("FAIL err_aligned_pc: pc=%h, required 00000100", obs_pc);
        end
        got++;
      end
    end
    repeat (4) tick();
    checks++;
    if (obs_err !== 1'b1 || got !== 1) begin
      errors++;
      $display("FAIL err_sticky: error=%b pops=%0d, required 1 1", obs_err, got);
    end
    do_reset();
    imem_req_ready = 1'b0;
    tick();
    checks++;
    if (obs_err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared: error=%b, required 0", obs_err);
    end
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    checks++;
    if (obs_err !== 1'b1) begin
      errors++;
      $display("FAIL err_spurious: error=%b, required 1", obs_err);
    end
    tick();
    checks++;
    if (obs_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_spur_ignored: out_valid=%b, required 0", obs_out_valid);
    end
  endtask

  task automatic test_random();
    int pops;
    logic [31:0] exp_pc;
    do_reset();
    pops = 0;
    exp_pc = 32'h0;
    for (int i = 0; i < 900; i++) begin
      imem_req_ready = ($urandom % 4) != 0;
      out_ready      = ($urandom % 3) != 0;
      mem_lat        = $urandom_range(1, 5);
      redirect_valid = (i < 850) && (($urandom % 30) == 0);
      redirect_pc    = 32'($urandom_range(0, 1023)) & 32'hFFFF_FFFC;
      tick();
      if (obs_pop) begin
        checks++;
        if (obs_pc !== exp_pc || obs_inst !== inst_of(exp_pc)) begin
          errors++;
          $display("FAIL random_scoreboard: cycle=%0d pc=%h inst=%h, required pc=%h inst=%h",
                   i, obs_pc, obs_inst, exp_pc, inst_of(exp_pc));
        end
        exp_pc += 32'd4;
        pops++;
      end
      if (redirect_valid) exp_pc = redirect_pc;
    end
    redirect_valid = 1'b0;
    checks++;
    if (pops < 100 || obs_err !== 1'b0) begin
      errors++;
      $display("FAIL random_summary: pops=%0d error=%b, required pops>=100 error=0", pops, obs_err);
    end
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_collide();
    test_error();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
